// File: rtl/ahb_pkg.sv
// Shared AHB bus constants, slave FSM encoding and byte-lane helper.
// Imported by the memory slave, master and arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    // Little-endian lanes touched by an aligned access of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << lo;
            HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mem_slave_sram.sv
// 32-bit SRAM bank with byte-lane write enables and a registered read
// port that sees same-cycle writes to the word being read.
module ahb_sram_bank #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
            if (waddr == raddr) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        rdata_d[8*i +: 8] = wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: pipelined transfers, configurable wait states,
// byte/half/word SRAM access and a two-cycle ERROR response.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [31:0]           hwdata,
    input  logic                  hmastlock,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [31:0]           hrdata
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;

    logic          open_phase, accept, misalign, illegal;
    logic          rd_now;
    logic [AW-1:0] haddr_widx, raddr;
    logic [3:0]    we;
    logic          unused_ok;

    assign unused_ok  = ^{hburst, hprot, hmastlock, htrans[0]};
    assign haddr_widx = AW'(haddr >> 2);

    assign open_phase = (state_q == ST_IDLE) || (state_q == ST_DONE)
                     || (state_q == ST_ERR2);
    assign accept     = open_phase & hsel & hready & htrans[1];
    assign misalign   = (hsize == HSIZE_HALF && haddr[0])
                     || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);
    assign illegal    = (64'(haddr) >= 64'(MEM_BYTES))
                     || (hsize > HSIZE_WORD) || misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        be_d    = be_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    widx_d  = haddr_widx;
                    be_d    = lane_mask(hsize, haddr[1:0]);
                    write_d = hwrite;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // Zero-wait reads fetch on the accept edge; waited reads on DONE entry.
    assign rd_now = (WAIT_STATES == 0)
                  ? (accept & ~illegal & ~hwrite)
                  : (state_q == ST_WAIT && cnt_q == 3'd0 && !write_q);
    assign raddr  = (state_q == ST_WAIT) ? widx_q : haddr_widx;
    assign we     = (state_q == ST_DONE && write_q) ? be_q : 4'b0000;

    ahb_sram_bank #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (hclk),
        .rst   (hreset),
        .we    (we),
        .waddr (widx_q),
        .wdata (hwdata),
        .re    (rd_now),
        .raddr (raddr),
        .rdata (hrdata)
    );

    assign hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2)
                     ? HRESP_ERROR : HRESP_OKAY;

endmodule
